change_return_dispenser: RTL
============================

Name: change_return_dispenser

Overview:
- Downstream of the coke vending FSM: takes the machine's current credit on a refund request and pays it out as physical coins.
- Drives one solenoid per coin hopper (1c, 5c, 10c), largest coin first, skipping hoppers that report empty.
- Tells the upstream stage to zero its credit, reports completion, and flags any amount it cannot pay.

Parameters:
- CREDIT_W, 7, width of credit and shortfall (matches the upstream credit output).
- EJECT_PULSE, 4, cycles each solenoid is energised per coin (must be ≥1).
- GAP_CYCLES, 2, idle cycles between consecutive ejects (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- refund  in  1  refund request; sampled only in IDLE.
- credit  in  CREDIT_W  upstream credit value; sampled only on refund acceptance.
- hopper_empty  in  3  bit0=1c, bit1=5c, bit2=10c; 1 = hopper empty.
- fault_clr  in  1  clears FAULT and returns to IDLE.
- eject  out  3  one-hot solenoid drive (bit0=1c, bit1=5c, bit2=10c).
- clear_credit  out  1  one-cycle pulse telling upstream to zero its credit.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when payout is complete.
- fault  out  1  held high while in FAULT.
- shortfall  out  CREDIT_W  unpaid amount; valid while fault=1, 0 otherwise.

Behaviour:
- Reset (async, any state, including mid-PULSE): state=IDLE; remaining, sel and counters cleared. All outputs go to 0 immediately (eject included).
- All outputs are registered or decoded from registered state only. No input reaches an output combinationally.
- States: IDLE, SELECT, PULSE, GAP, DONE, FAULT.
- IDLE:
  - refund=1 and credit≠0 at edge k: remaining←credit; clear_credit=1 during cycle k+1 only; state→SELECT.
  - refund=1 and credit=0: state→DONE, with no clear_credit and no eject.
- SELECT (1 cycle):
  - remaining=0 → DONE.
  - Otherwise pick the largest d in {10,5,1} with remaining≥d and hopper_empty[d]=0; sel←d; counter←EJECT_PULSE-1; →PULSE.
  - No candidate → FAULT; shortfall←remaining.
  - hopper_empty is sampled only here; changes during PULSE or GAP are ignored.
- PULSE:
  - eject[sel]=1, other bits 0, for exactly EJECT_PULSE cycles.
  - On the last cycle, remaining←remaining−value(sel); counter←GAP_CYCLES-1; →GAP.
- GAP: eject=0 for exactly GAP_CYCLES cycles, then →SELECT.
- DONE: done=1 for one cycle, then →IDLE.
- FAULT: fault=1 and shortfall held; eject=0. fault_clr=1 → IDLE with shortfall←0. reset also exits.
- While busy, refund and credit changes are ignored. There is no queuing, and a refund held high through completion is re-accepted on the first IDLE cycle after DONE.
- Arithmetic:
  - remaining is CREDIT_W bits and never underflows, because a coin is only selected when remaining≥value.
  - Max credit 127 is supported.
- Per-coin time is 1+EJECT_PULSE+GAP_CYCLES cycles (default 7).
- Payout latency with defaults, refund accepted at edge k:
  - First eject rises at k+2.
  - done is high at k+1+7·N+1 for N coins.
- eject is never multi-hot, and is never high outside PULSE.

Test Plan:
- credit=16, all hoppers full, refund pulse → clear_credit 1 cycle; eject=100, 010, 001 in order, each 4 cycles with 2-cycle gaps; done at k+23; busy low after.
- credit=30, hopper_empty=100 → six eject=010 pulses, 4 cycles each; no 10c eject; done pulse; fault=0.
- credit=0, refund → done pulse at k+1 (state DONE at k+1); eject stays 000; clear_credit stays 0.
- credit=3, hopper_empty=001 → fault=1, shortfall=3 held, no eject; fault_clr → IDLE, shortfall=0.
- credit=12, second refund pulse and credit=99 mid-payout → both ignored; exactly 10c then 1c then 1c ejected; a single done pulse.
- Reset asserted during the 3rd PULSE cycle of a 10c eject → eject, busy, clear_credit and done go 0 immediately; after release, IDLE; next refund behaves normally.

Source files
------------

// File: rtl/change_return_dispenser.sv
// change_return_dispenser: pays out refunded credit as 10c/5c/1c coins,
// largest first, skipping empty hoppers and flagging any unpaid amount.
module change_return_dispenser #(
  parameter int CREDIT_W    = 7,
  parameter int EJECT_PULSE = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                refund,
  input  logic [CREDIT_W-1:0] credit,
  input  logic [2:0]          hopper_empty,
  input  logic                fault_clr,
  output logic [2:0]          eject,
  output logic                clear_credit,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [CREDIT_W-1:0] shortfall
);

  localparam int CMAX  = (EJECT_PULSE > GAP_CYCLES) ? EJECT_PULSE : GAP_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE,
    FAULT
  } state_t;

  state_t              state, state_n;
  logic [CREDIT_W-1:0] remaining, rem_n;
  logic [CREDIT_W-1:0] short_q, short_n;
  logic [2:0]          sel, sel_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                clr_q, clr_n;
  logic [CREDIT_W-1:0] val;

  // coin value of the currently selected hopper
  always_comb begin
    val = '0;
    unique case (1'b1)
      sel[2]:  val = CREDIT_W'(10);
      sel[1]:  val = CREDIT_W'(5);
      sel[0]:  val = CREDIT_W'(1);
      default: val = '0;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      short_q   <= '0;
      sel       <= '0;
      cnt       <= '0;
      clr_q     <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      short_q   <= short_n;
      sel       <= sel_n;
      cnt       <= cnt_n;
      clr_q     <= clr_n;
    end
  end

  // next-state logic: coin selection, pulse/gap timing, fault handling
  always_comb begin
    state_n = state;
    rem_n   = remaining;
    short_n = short_q;
    sel_n   = sel;
    cnt_n   = cnt;
    clr_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (refund) begin
          if (credit != '0) begin
            rem_n   = credit;
            clr_n   = 1'b1;
            state_n = SELECT;
          end else begin
            state_n = DONE;
          end
        end
      end
      SELECT: begin
        cnt_n = CNT_W'(EJECT_PULSE - 1);
        if (remaining == '0) begin
          state_n = DONE;
        end else if (remaining >= CREDIT_W'(10) && !hopper_empty[2]) begin
          sel_n   = 3'b100;
          state_n = PULSE;
        end else if (remaining >= CREDIT_W'(5) && !hopper_empty[1]) begin
          sel_n   = 3'b010;
          state_n = PULSE;
        end else if (!hopper_empty[0]) begin
          sel_n   = 3'b001;
          state_n = PULSE;
        end else begin
          short_n = remaining;
          state_n = FAULT;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          rem_n   = remaining - val;
          cnt_n   = CNT_W'(GAP_CYCLES - 1);
          state_n = GAP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = SELECT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: state_n = IDLE;
      FAULT: begin
        if (fault_clr) begin
          short_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    eject        = (state == PULSE) ? sel : 3'b000;
    clear_credit = clr_q;
    busy         = (state != IDLE);
    done         = (state == DONE);
    fault        = (state == FAULT);
    shortfall    = short_q;
  end

endmodule
